// File: rtl/vx_dcache_req_queue.sv
// rtl/vx_dcache_req_queue.sv - per-lane elastic dcache request queue with occupancy, flush and lockstep accept
module vx_dcache_req_queue #(
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH      = 4,
    parameter int LOCKSTEP   = 0,
    localparam int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_REQS-1:0]               in_valid,
    input  logic [NUM_REQS-1:0]               in_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     in_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    in_addr,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0]   in_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     in_tag,
    output logic [NUM_REQS-1:0]               in_ready,
    output logic [NUM_REQS-1:0]               out_valid,
    output logic [NUM_REQS-1:0]               out_rw,
    output logic [NUM_REQS*WORD_SIZE-1:0]     out_byteen,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]    out_addr,
    output logic [NUM_REQS*8*WORD_SIZE-1:0]   out_data,
    output logic [NUM_REQS*TAG_WIDTH-1:0]     out_tag,
    input  logic [NUM_REQS-1:0]               out_ready,
    output logic [NUM_REQS*CNTW-1:0]          count
);

    localparam int DW = 8 * WORD_SIZE;
    localparam int PW = $clog2(DEPTH);
    localparam int BW = 1 + WORD_SIZE + ADDR_WIDTH + DW + TAG_WIDTH;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [NUM_REQS-1:0] full;
    logic [NUM_REQS-1:0] push;
    logic [NUM_REQS-1:0] pop;

    // Readiness never looks at this cycle's pop, so a full lane stays blocked.
    generate
        if (LOCKSTEP != 0) begin : g_lockstep
            logic all_ok;
            assign all_ok   = ~reset & ~flush & ~(|(in_valid & full));
            assign in_ready = {NUM_REQS{all_ok}};
        end else begin : g_independent
            assign in_ready = ~full & {NUM_REQS{~reset & ~flush}};
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
            logic [PW-1:0]   wptr;
            logic [PW-1:0]   rptr;
            logic [CNTW-1:0] cnt;
            logic [BW-1:0]   mem [DEPTH];
            logic [BW-1:0]   wr_bundle;
            logic [BW-1:0]   head;

            assign wr_bundle = {in_rw[i],
                                in_byteen[i*WORD_SIZE +: WORD_SIZE],
                                in_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                in_data[i*DW +: DW],
                                in_tag[i*TAG_WIDTH +: TAG_WIDTH]};

            assign full[i]      = (cnt == FULL_CNT);
            assign out_valid[i] = (cnt != '0);
            assign push[i]      = in_valid[i] & in_ready[i];
            assign pop[i]       = out_valid[i] & out_ready[i];

            // Storage is deliberately left out of reset; cnt gates visibility.
            always_ff @(posedge clk) begin
                if (push[i]) begin
                    mem[wptr] <= wr_bundle;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wptr <= '0;
                    rptr <= '0;
                    cnt  <= '0;
                end else if (flush) begin
                    wptr <= '0;
                    rptr <= '0;
                    cnt  <= '0;
                end else begin
                    if (push[i]) begin
                        wptr <= wptr + PW'(1);
                    end
                    if (pop[i]) begin
                        rptr <= rptr + PW'(1);
                    end
                    case ({push[i], pop[i]})
                        2'b10:   cnt <= cnt + CNTW'(1);
                        2'b01:   cnt <= cnt - CNTW'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end

            assign head = out_valid[i] ? mem[rptr] : '0;

            assign {out_rw[i],
                    out_byteen[i*WORD_SIZE +: WORD_SIZE],
                    out_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                    out_data[i*DW +: DW],
                    out_tag[i*TAG_WIDTH +: TAG_WIDTH]} = head;

            assign count[i*CNTW +: CNTW] = cnt;
        end
    endgenerate

endmodule

// File: tb/tb_vx_dcache_req_queue.sv
// tb/tb_vx_dcache_req_queue.sv - scoreboard bench for vx_dcache_req_queue
module tb_vx_dcache_req_queue;

    localparam int NR = 4;
    localparam int WS = 4;
    localparam int AW = 30;
    localparam int TW = 8;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int DW = 32;

    typedef logic [1+WS+AW+DW+TW-1:0] bundle_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [NR-1:0]    in_valid, in_rw, in_ready, out_valid, out_rw, out_ready;
    logic [NR*WS-1:0] in_byteen, out_byteen;
    logic [NR*AW-1:0] in_addr, out_addr;
    logic [NR*DW-1:0] in_data, out_data;
    logic [NR*TW-1:0] in_tag, out_tag;
    logic [NR*CW-1:0] count;

    logic [NR-1:0]    ls_in_valid, ls_in_ready, ls_out_valid, ls_out_rw, ls_out_ready;
    logic [NR*WS-1:0] ls_out_byteen;
    logic [NR*AW-1:0] ls_out_addr;
    logic [NR*DW-1:0] ls_out_data;
    logic [NR*TW-1:0] ls_in_tag, ls_out_tag;
    logic [NR*CW-1:0] ls_count;

    bundle_t sb [NR][$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vx_dcache_req_queue #(.NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                          .DEPTH(D), .LOCKSTEP(0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_rw(in_rw), .in_byteen(in_byteen), .in_addr(in_addr),
        .in_data(in_data), .in_tag(in_tag), .in_ready(in_ready),
        .out_valid(out_valid), .out_rw(out_rw), .out_byteen(out_byteen), .out_addr(out_addr),
        .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready), .count(count)
    );

    vx_dcache_req_queue #(.NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
                          .DEPTH(D), .LOCKSTEP(1)) u_ls (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(ls_in_valid), .in_rw('0), .in_byteen('0), .in_addr('0),
        .in_data('0), .in_tag(ls_in_tag), .in_ready(ls_in_ready),
        .out_valid(ls_out_valid), .out_rw(ls_out_rw), .out_byteen(ls_out_byteen), .out_addr(ls_out_addr),
        .out_data(ls_out_data), .out_tag(ls_out_tag), .out_ready(ls_out_ready), .count(ls_count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bundle_t in_bundle(input int l);
        return {in_rw[l], in_byteen[l*WS +: WS], in_addr[l*AW +: AW], in_data[l*DW +: DW], in_tag[l*TW +: TW]};
    endfunction

    function automatic bundle_t out_bundle(input int l);
        return {out_rw[l], out_byteen[l*WS +: WS], out_addr[l*AW +: AW], out_data[l*DW +: DW], out_tag[l*TW +: TW]};
    endfunction

    task automatic set_lane(input int l, input logic v, input logic rw, input logic [WS-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
        in_valid[l]          = v;
        in_rw[l]             = rw;
        in_byteen[l*WS +: WS] = be;
        in_addr[l*AW +: AW]   = a;
        in_data[l*DW +: DW]   = d;
        in_tag[l*TW +: TW]    = t;
    endtask

    // Compares the DUT against the queue model for the current cycle, then advances one clock.
    task automatic cycle();
        bundle_t exp_b;
        bit      mr;
        #1;
        for (int l = 0; l < NR; l++) begin
            mr = !flush && (sb[l].size() < D);
            chk($sformatf("in_ready[%0d]", l), in_ready[l], mr);
            chk($sformatf("count[%0d]", l), count[l*CW +: CW], sb[l].size());
            chk($sformatf("out_valid[%0d]", l), out_valid[l], sb[l].size() != 0);
            if (sb[l].size() == 0) begin
                chk($sformatf("idle_payload[%0d]", l), out_bundle(l), '0);
            end else if (out_ready[l] && !flush) begin
                exp_b = sb[l].pop_front();
                chk($sformatf("pop[%0d]", l), out_bundle(l), exp_b);
            end else begin
                chk($sformatf("head[%0d]", l), out_bundle(l), sb[l][0]);
            end
            if (in_valid[l] && mr) begin
                sb[l].push_back(in_bundle(l));
            end
        end
        if (flush) begin
            for (int l = 0; l < NR; l++) sb[l].delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ls_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = '0; in_rw = '0; in_byteen = '0; in_addr = '0; in_data = '0; in_tag = '0;
        out_ready = '0; ls_in_valid = '0; ls_in_tag = '0; ls_out_ready = '0;
        #12;
        chk("rst_out_valid", out_valid, '0);
        chk("rst_in_ready", in_ready, '0);
        chk("rst_count", count, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_tag", out_tag, '0);
        @(negedge clk);
        reset = 1'b0;

        // single write on lane0, visible one cycle later
        set_lane(0, 1'b1, 1'b1, 4'hF, 30'h100, 32'hDEADBEEF, 8'h12);
        cycle();
        set_lane(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 8'h0);
        #1;
        chk("t1_rw", out_rw[0], 1'b1);
        chk("t1_addr", out_addr[AW-1:0], 30'h100);
        chk("t1_data", out_data[DW-1:0], 32'hDEADBEEF);
        chk("t1_byteen", out_byteen[WS-1:0], 4'hF);
        chk("t1_tag", out_tag[TW-1:0], 8'h12);
        chk("t1_count", count[CW-1:0], 3'd1);
        cycle();
        out_ready[0] = 1'b1;
        cycle();
        out_ready[0] = 1'b0;

        // fill lane1 to full, attempt a fifth push, then drain in order
        for (int k = 1; k <= 5; k++) begin
            set_lane(1, 1'b1, 1'b0, 4'h3, 30'(32'h200 + k), 32'(k * 16'h1111), 8'(k));
            cycle();
        end
        set_lane(1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 8'h0);
        #1;
        chk("t2_full_count", count[1*CW +: CW], 3'd4);
        chk("t2_full_ready", in_ready[1], 1'b0);
        out_ready[1] = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        out_ready[1] = 1'b0;

        // lane2 steady state at count 2 with pointer wrap
        for (int k = 0; k < 2; k++) begin
            set_lane(2, 1'b1, 1'b1, 4'h5, 30'(32'h300 + k), $urandom, 8'(8'h40 + k));
            cycle();
        end
        out_ready[2] = 1'b1;
        for (int k = 2; k < 12; k++) begin
            set_lane(2, 1'b1, k[0], 4'(k), 30'(32'h300 + k), $urandom, 8'(8'h40 + k));
            cycle();
            chk("t3_steady_count", count[2*CW +: CW], 3'd2);
        end
        set_lane(2, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 8'h0);
        for (int k = 0; k < 3; k++) cycle();
        out_ready[2] = 1'b0;

        // lanes at counts 1..4, then flush with everything asserted
        for (int k = 0; k < NR; k++) begin
            for (int l = 0; l < NR; l++) begin
                set_lane(l, l >= k, 1'b0, 4'hA, 30'(l * 64 + k), $urandom, 8'(l * 16 + k));
            end
            cycle();
        end
        flush = 1'b1; in_valid = '1; out_ready = '1;
        cycle();
        flush = 1'b0; in_valid = '0; out_ready = '0;
        #1;
        chk("t5_count", count, '0);
        chk("t5_out_valid", out_valid, '0);
        cycle();

        // async reset between edges with all lanes non-empty
        for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 1'b1, 4'hC, 30'(l), $urandom, 8'(8'h80 + l));
        cycle();
        in_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, '0);
        chk("t6_count", count, '0);
        chk("t6_in_ready", in_ready, '0);
        for (int l = 0; l < NR; l++) sb[l].delete();
        @(negedge clk);
        reset = 1'b0;
        set_lane(3, 1'b1, 1'b0, 4'h1, 30'h3FF, 32'h1234_5678, 8'h77);
        cycle();
        set_lane(3, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 8'h0);
        out_ready[3] = 1'b1;
        cycle();
        out_ready[3] = 1'b0;
        cycle();

        // lockstep instance: full lane3 blocks lane0 as well
        for (int k = 0; k < D; k++) begin
            ls_in_valid = 4'b1000;
            ls_in_tag[3*TW +: TW] = 8'(8'hA0 + k);
            ls_step();
        end
        ls_in_valid = 4'b1001;
        ls_in_tag = {8'hB3, 8'h00, 8'h00, 8'hB0};
        chk("ls_blocked_ready", ls_in_ready, 4'b0000);
        ls_step();
        chk("ls_lane0_count", ls_count[CW-1:0], 3'd0);
        chk("ls_lane3_count", ls_count[3*CW +: CW], 3'd4);
        chk("ls_head_tag", ls_out_tag[3*TW +: TW], 8'hA0);
        ls_out_ready = 4'b1000;
        ls_step();
        ls_out_ready = 4'b0000;
        #1;
        chk("ls_ready_after_pop", ls_in_ready, 4'b1111);
        chk("ls_next_head", ls_out_tag[3*TW +: TW], 8'hA1);
        ls_step();
        ls_in_valid = 4'b0000;
        chk("ls_lane0_pushed", ls_count[CW-1:0], 3'd1);
        chk("ls_lane3_pushed", ls_count[3*CW +: CW], 3'd4);
        chk("ls_lane0_tag", ls_out_tag[TW-1:0], 8'hB0);
        chk("ls_idle_lanes", ls_count[1*CW +: 2*CW], '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
